// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings, pipeline entry records and helpers for the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int RA_W = 5;
  localparam int T_W  = 2;

  localparam logic [T_W-1:0] TUSE_D    = 2'd0;
  localparam logic [T_W-1:0] TUSE_E    = 2'd1;
  localparam logic [T_W-1:0] TUSE_M    = 2'd2;
  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  localparam logic [T_W-1:0] TNEW_PC8  = 2'd0;
  localparam logic [T_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [T_W-1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic            valid;
    logic            wr_en;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] wr_addr;
    logic [T_W-1:0]  tnew;
  } e_entry_t;

  typedef struct packed {
    logic            valid;
    logic            wr_en;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] wr_addr;
    logic [T_W-1:0]  tnew;
  } m_entry_t;

  typedef struct packed {
    logic            valid;
    logic            wr_en;
    logic [RA_W-1:0] wr_addr;
  } w_entry_t;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Bypass select for an operand already past D: M beats W, and an M match
  // whose result is not ready yet blocks the stale W value.
  function automatic logic [1:0] late_fwd(input logic [RA_W-1:0] addr,
                                          input logic m_live, input logic [RA_W-1:0] m_addr,
                                          input logic [T_W-1:0] m_tnew,
                                          input logic w_live, input logic [RA_W-1:0] w_addr);
    if (addr == '0) return FWD_RF;
    if (m_live && m_addr == addr) return (m_tnew == '0) ? FWD_M : FWD_RF;
    if (w_live && w_addr == addr) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request and hazard/bypass response bundle of the hazard scoreboard.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic [RA_W-1:0] d_rs;
  logic [RA_W-1:0] d_rt;
  logic [T_W-1:0]  d_tuse_rs;
  logic [T_W-1:0]  d_tuse_rt;
  logic            d_wr_en;
  logic [RA_W-1:0] d_wr_addr;
  logic [T_W-1:0]  d_tnew;
  logic            stall;
  logic [1:0]      d_fwd_rs;
  logic [1:0]      d_fwd_rt;
  logic [1:0]      e_fwd_rs;
  logic [1:0]      e_fwd_rt;
  logic            m_fwd_rt;
  logic [31:0]     stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wr_addr, d_tnew,
    input  stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wr_addr, d_tnew,
    output stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: one D-stage source (address + T_use) against the E/M/W writers.
module hazard_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [RA_W-1:0] i_addr,
  input  logic [T_W-1:0]  i_tuse,
  input  logic            i_e_live,
  input  logic [RA_W-1:0] i_e_addr,
  input  logic [T_W-1:0]  i_e_tnew,
  input  logic            i_m_live,
  input  logic [RA_W-1:0] i_m_addr,
  input  logic [T_W-1:0]  i_m_tnew,
  input  logic            i_w_live,
  input  logic [RA_W-1:0] i_w_addr,
  output logic            o_stall,
  output logic [1:0]      o_fwd
);

  logic           w_hit_e, w_hit_m, w_hit_w, w_any;
  logic [T_W-1:0] w_tnew;
  logic [1:0]     w_code;

  assign w_hit_e = (i_addr != '0) && i_e_live && (i_e_addr == i_addr);
  assign w_hit_m = (i_addr != '0) && i_m_live && (i_m_addr == i_addr);
  assign w_hit_w = (i_addr != '0) && i_w_live && (i_w_addr == i_addr);
  assign w_any   = w_hit_e || w_hit_m || w_hit_w;

  // Only the youngest matching writer counts; older ones hold stale values.
  always_comb begin
    w_tnew = '0;
    w_code = FWD_RF;
    if (w_hit_e) begin
      w_tnew = i_e_tnew;
      w_code = FWD_E;
    end else if (w_hit_m) begin
      w_tnew = i_m_tnew;
      w_code = FWD_M;
    end else if (w_hit_w) begin
      w_code = FWD_W;
    end
  end

  assign o_stall = w_any && (i_tuse != TUSE_NONE) && (w_tnew > i_tuse);
  assign o_fwd   = (w_any && w_tnew == '0) ? w_code : FWD_RF;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers through E/M/W and derives stall and bypass selects.
// Optional stall statistics counter enabled with macro HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  hazard_scoreboard_if.slave bus
);

  e_entry_t r_e;
  m_entry_t r_m;
  w_entry_t r_w;

  logic w_e_live, w_m_live, w_w_live;
  logic w_stall_rs, w_stall_rt, w_stall;

  assign w_e_live = r_e.valid && r_e.wr_en && (r_e.wr_addr != '0);
  assign w_m_live = r_m.valid && r_m.wr_en && (r_m.wr_addr != '0);
  assign w_w_live = r_w.valid && r_w.wr_en && (r_w.wr_addr != '0);

  hazard_match u_match_rs (
    .i_addr   (bus.d_rs),      .i_tuse   (bus.d_tuse_rs),
    .i_e_live (w_e_live),      .i_e_addr (r_e.wr_addr), .i_e_tnew (r_e.tnew),
    .i_m_live (w_m_live),      .i_m_addr (r_m.wr_addr), .i_m_tnew (r_m.tnew),
    .i_w_live (w_w_live),      .i_w_addr (r_w.wr_addr),
    .o_stall  (w_stall_rs),    .o_fwd    (bus.d_fwd_rs)
  );

  hazard_match u_match_rt (
    .i_addr   (bus.d_rt),      .i_tuse   (bus.d_tuse_rt),
    .i_e_live (w_e_live),      .i_e_addr (r_e.wr_addr), .i_e_tnew (r_e.tnew),
    .i_m_live (w_m_live),      .i_m_addr (r_m.wr_addr), .i_m_tnew (r_m.tnew),
    .i_w_live (w_w_live),      .i_w_addr (r_w.wr_addr),
    .o_stall  (w_stall_rt),    .o_fwd    (bus.d_fwd_rt)
  );

  assign w_stall   = w_stall_rs || w_stall_rt;
  assign bus.stall = w_stall;

  assign bus.e_fwd_rs = late_fwd(r_e.rs, w_m_live, r_m.wr_addr, r_m.tnew, w_w_live, r_w.wr_addr);
  assign bus.e_fwd_rt = late_fwd(r_e.rt, w_m_live, r_m.wr_addr, r_m.tnew, w_w_live, r_w.wr_addr);
  assign bus.m_fwd_rt = (r_m.rt != '0) && w_w_live && (r_w.wr_addr == r_m.rt);

  // A stalled D instruction stays put, so E receives an all-zero bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_w.valid   <= r_m.valid;
      r_w.wr_en   <= r_m.wr_en;
      r_w.wr_addr <= r_m.wr_addr;
      r_m.valid   <= r_e.valid;
      r_m.wr_en   <= r_e.wr_en;
      r_m.rt      <= r_e.rt;
      r_m.wr_addr <= r_e.wr_addr;
      r_m.tnew    <= sat_dec(r_e.tnew);
      if (w_stall) begin
        r_e <= '0;
      end else begin
        r_e.valid   <= 1'b1;
        r_e.wr_en   <= bus.d_wr_en;
        r_e.rs      <= bus.d_rs;
        r_e.rt      <= bus.d_rt;
        r_e.wr_addr <= bus.d_wr_addr;
        r_e.tnew    <= bus.d_tnew;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard plus a reset-during-stall sequence.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] trs, trt;
    logic       we;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       st;
    logic [1:0] dfs, dft, efs, eft;
    logic       mft;
  } vec_t;

  localparam int NVEC = 39;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   stallSum;
  vec_t vecs [NVEC];

  hazard_scoreboard_if hz ();

  hazard_scoreboard dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] trs, input logic [1:0] trt,
                              input logic we, input logic [4:0] wa, input logic [1:0] tn,
                              input logic st, input logic [1:0] dfs, input logic [1:0] dft,
                              input logic [1:0] efs, input logic [1:0] eft, input logic mft);
    vec_t v;
    v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt; v.we = we; v.wa = wa; v.tn = tn;
    v.st = st; v.dfs = dfs; v.dft = dft; v.efs = efs; v.eft = eft; v.mft = mft;
    return v;
  endfunction

  function automatic vec_t nop(input logic [1:0] efs, input logic [1:0] eft, input logic mft);
    return mk(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, TNEW_PC8,
              1'b0, FWD_RF, FWD_RF, efs, eft, mft);
  endfunction

  task automatic applyStimulus(input vec_t v);
    hz.d_rs      = v.rs;
    hz.d_rt      = v.rt;
    hz.d_tuse_rs = v.trs;
    hz.d_tuse_rt = v.trt;
    hz.d_wr_en   = v.we;
    hz.d_wr_addr = v.wa;
    hz.d_tnew    = v.tn;
  endtask

  task automatic checkOutput(input string name, input vec_t v, input logic [31:0] expCnt);
    logic [9:0] got, exp;
    got = {hz.stall, hz.d_fwd_rs, hz.d_fwd_rt, hz.e_fwd_rs, hz.e_fwd_rt, hz.m_fwd_rt};
    exp = {v.st, v.dfs, v.dft, v.efs, v.eft, v.mft};
    vectors++;
    if (got !== exp || hz.stall_cnt !== expCnt) begin
      miscompares++;
      $display("[TB] FAIL %s: stall/dfs/dft/efs/eft/mfwd got %b cnt %0d, expected %b cnt %0d",
               name, got, hz.stall_cnt, exp, expCnt);
    end
  endtask

  initial begin
    vec_t lwV, addV;
    vectors     = 0;
    miscompares = 0;
    stallSum    = 0;

    // rs, rt, tuse_rs, tuse_rt, wr_en, wr_addr, tnew | stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt
    vecs[0]  = nop(0, 0, 0);
    vecs[1]  = mk(3, 4, TUSE_E, TUSE_E, 1, 1, TNEW_ALU, 0, 0, 0, 0, 0, 0);       // add $1,$3,$4
    vecs[2]  = mk(1, 1, TUSE_E, TUSE_E, 1, 2, TNEW_ALU, 0, 0, 0, 0, 0, 0);       // add $2,$1,$1
    vecs[3]  = nop(FWD_M, FWD_M, 0);
    vecs[4]  = nop(0, 0, 1);
    vecs[5]  = nop(0, 0, 0);
    vecs[6]  = mk(3, 1, TUSE_E, TUSE_NONE, 1, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0);   // lw $1,0($3)
    vecs[7]  = mk(1, 3, TUSE_E, TUSE_E, 1, 2, TNEW_ALU, 1, 0, 0, 0, 0, 0);       // add $2,$1,$3
    vecs[8]  = mk(1, 3, TUSE_E, TUSE_E, 1, 2, TNEW_ALU, 0, 0, 0, 0, 0, 0);
    vecs[9]  = nop(FWD_W, 0, 0);
    vecs[10] = nop(0, 0, 0);
    vecs[11] = nop(0, 0, 0);
    vecs[12] = mk(3, 1, TUSE_E, TUSE_NONE, 1, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0);   // lw $1,0($3)
    vecs[13] = mk(1, 0, TUSE_D, TUSE_D, 0, 0, TNEW_PC8, 1, 0, 0, 0, 0, 0);       // beq $1,$0
    vecs[14] = mk(1, 0, TUSE_D, TUSE_D, 0, 0, TNEW_PC8, 1, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, TUSE_D, TUSE_D, 0, 0, TNEW_PC8, 0, FWD_W, 0, 0, 0, 0);
    vecs[16] = nop(0, 0, 0);
    vecs[17] = nop(0, 0, 0);
    vecs[18] = mk(0, 31, TUSE_E, TUSE_NONE, 1, 31, TNEW_ALU, 0, 0, 0, 0, 0, 0);  // ori $31,$0,5
    vecs[19] = mk(0, 0, TUSE_NONE, TUSE_NONE, 1, 31, TNEW_PC8, 0, 0, 0, 0, 0, 0);// jal
    vecs[20] = mk(31, 0, TUSE_D, TUSE_NONE, 0, 0, TNEW_PC8, 0, FWD_E, 0, 0, 0, 0);// jr $31
    vecs[21] = nop(FWD_M, 0, 0);
    vecs[22] = nop(0, 0, 0);
    vecs[23] = mk(1, 2, TUSE_E, TUSE_E, 1, 5, TNEW_ALU, 0, 0, 0, 0, 0, 0);       // add $5,$1,$2
    vecs[24] = mk(6, 5, TUSE_E, TUSE_M, 0, 0, TNEW_PC8, 0, 0, 0, 0, 0, 0);       // sw $5,0($6)
    vecs[25] = nop(0, FWD_M, 0);
    vecs[26] = nop(0, 0, 1);
    vecs[27] = nop(0, 0, 0);
    vecs[28] = mk(1, 0, TUSE_E, TUSE_NONE, 1, 0, TNEW_LOAD, 0, 0, 0, 0, 0, 0);   // lw $0,0($1)
    vecs[29] = mk(0, 0, TUSE_E, TUSE_E, 1, 2, TNEW_ALU, 0, 0, 0, 0, 0, 0);       // add $2,$0,$0
    vecs[30] = nop(0, 0, 0);
    vecs[31] = mk(1, 7, TUSE_E, TUSE_NONE, 1, 7, TNEW_LOAD, 0, 0, 0, 0, 0, 0);   // lw $7,0($1)
    vecs[32] = mk(7, 7, TUSE_E, TUSE_E, 1, 8, TNEW_ALU, 1, 0, 0, 0, 0, 0);       // add $8,$7,$7
    vecs[33] = mk(7, 7, TUSE_E, TUSE_E, 1, 8, TNEW_ALU, 0, 0, 0, 0, 0, 0);
    vecs[34] = nop(FWD_W, FWD_W, 0);
    vecs[35] = nop(0, 0, 0);
    vecs[36] = mk(1, 2, TUSE_E, TUSE_E, 1, 9, TNEW_ALU, 0, 0, 0, 0, 0, 0);       // add $9,$1,$2
    vecs[37] = nop(0, 0, 0);
    vecs[38] = mk(9, 8, TUSE_D, TUSE_D, 0, 0, TNEW_PC8, 0, FWD_M, 0, 0, 0, 0);   // beq $9,$8

    reset_n = 1'b0;
    applyStimulus(nop(0, 0, 0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i], STATS ? 32'(stallSum) : 32'd0);
      if (vecs[i].st) stallSum++;
    end

    // Drain the pipeline, then reset while a load-use stall is being raised.
    repeat (3) begin
      @(negedge clk);
      applyStimulus(nop(0, 0, 0));
    end
    lwV  = mk(3, 1, TUSE_E, TUSE_NONE, 1, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0);
    addV = mk(1, 3, TUSE_E, TUSE_E, 1, 2, TNEW_ALU, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(lwV);
    #1 checkOutput("rst_seq_lw", lwV, STATS ? 32'(stallSum) : 32'd0);
    @(negedge clk);
    applyStimulus(addV);
    reset_n = 1'b0;
    #1 checkOutput("rst_seq_stall", addV, STATS ? 32'(stallSum) : 32'd0);
    addV.st = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1 checkOutput("rst_seq_cleared", addV, 32'd0);
    @(negedge clk);
    #1 checkOutput("rst_seq_after", addV, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
